ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit that sits beside the ALU/BRU/LSU inside the EX stage.
- Parametrised in data width, with RV64 word-op (*W) support.
- Drives the EX stage's stall request while an operation is in flight, so the rest of the pipeline freezes until the result is ready.
- Holds the result stable until the EX stage reports that the instruction has advanced.

Parameters:
- XLEN, 64, datapath width in bits (32 or 64).
- HAS_WORD_OPS, 1, enables *W variants (only legal when XLEN=64; tie to 0 for XLEN=32).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  branch/pipeline flush; kills any operation.
- start  in  1  valid M-extension instruction present in EX; held high while EX is stalled.
- op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_w  in  1  word variant; ignored when HAS_WORD_OPS=0.
- src_a  in  XLEN  forwarded rs1 value.
- src_b  in  XLEN  forwarded rs2 value.
- advance  in  1  EX instruction moves to MEM this cycle.
- result  out  XLEN  final rd value, registered.
- done  out  1  result valid.
- busy  out  1  operation in CALC.
- stallreq  out  1  combinational stall request to the hazard/stall controller.

Behaviour:
- Reset and interface: reset is synchronous on rst_n, active-low; clock is clk.
- Reset values: state=IDLE; result=0, done=0, busy=0, stallreq=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start=1, latch op, op_w, operands and the sign flags.
  - Special case (divide with divisor==0, or signed divide overflow: dividend=most-negative and divisor=-1, evaluated at operative width) → DONE next cycle with the RISC-V result:
    - DIV/DIVU by zero → all ones.
    - REM/REMU by zero → dividend.
    - Overflow DIV → dividend.
    - Overflow REM → 0.
  - Otherwise → CALC with counter = N, where N = 32 if op_w else XLEN.
- CALC (busy=1):
  - Multiply: radix-2 shift-add on operand magnitudes, 2*XLEN-bit product.
  - Divide: restoring, one quotient bit per cycle on magnitudes.
  - Counter decrements each cycle; at counter==1 → DONE.
- Result selection and sign correction:
  - Sign correction is applied on the CALC→DONE transition; the registered result is written in that same transition.
  - MUL → low XLEN bits. MULH/MULHSU/MULHU → high XLEN bits.
  - MULHSU: only src_a is signed.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- Word ops:
  - Use the low 32 bits of each operand.
  - Result is the low 32 bits, sign-extended to XLEN.
  - op_w with op 001–011 is treated as MULW.
- Latency:
  - Normal op: start seen at cycle t → done=1 at t+N+1.
  - Special-case op: done=1 at t+1.
- DONE (done=1, busy=0):
  - result is held stable.
  - start is ignored, because it is the same instruction.
  - On advance=1 → IDLE. In that same cycle a new start is not accepted; it is accepted from the next cycle.
- stallreq = (IDLE & start & !flush) | CALC. It is 0 in DONE.
- flush=1 in any state → IDLE next cycle; done, busy and the counter are cleared. flush has priority over start and advance.
- rst_n=0 mid-operation behaves identically to flush and also clears result.
- Operands are sampled only in IDLE; changes on src_a/src_b during CALC have no effect.
- done is never asserted in the same cycle as busy.

Test Plan:
- XLEN=64, MUL 7 × -3, advance held low → stallreq high 65 cycles; done at t+65; result 0xFFFFFFFFFFFFFFEB; then advance=1 → IDLE, done=0.
- MULHU all-ones × all-ones → 0xFFFFFFFFFFFFFFFE. MULH −1 × −1 → 0. MULHSU −1 × 2 → 0xFFFFFFFFFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFFFFFFFFFD. REM −7 / 2 → 0xFFFFFFFFFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2. Each completes with done at t+65.
- Special cases, each with done at t+1:
  - DIVU 5 / 0 → all ones.
  - REM 5 / 0 → 5.
  - DIV 0x8000000000000000 / −1 → 0x8000000000000000.
  - REM 0x8000000000000000 / −1 → 0.
- Word ops:
  - DIVW src_a=0x0000000180000000, src_b=−1 → overflow path; 0xFFFFFFFF80000000 at t+1.
  - MULW 0x40000000 × 2 → 0xFFFFFFFF80000000 at t+33.
- flush asserted at cycle 10 of a DIV → IDLE next cycle; busy=0; done never pulses.
- A new MUL 3 × 4 issued afterwards → 12.
- In DONE with advance low for 5 cycles and start high → no restart; result unchanged.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// EX-stage handshake between the pipeline and the iterative multiply/divide unit.
interface ex_muldiv_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            start;
    logic [2:0]      op;
    logic            op_w;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            advance;
    logic [XLEN-1:0] result;
    logic            done;
    logic            busy;
    logic            stallreq;

    modport master (
        output flush, start, op, op_w, src_a, src_b, advance,
        input  result, done, busy, stallreq
    );

    modport slave (
        input  flush, start, op, op_w, src_a, src_b, advance,
        output result, done, busy, stallreq
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// Multiplies by radix-2 shift-add and divides by restoring division, both on
// operand magnitudes; the sign is fixed up when the last iteration retires.
//
// state | meaning
// IDLE  | waiting for an M instruction; divide special cases resolve here
// CALC  | iterating, one product/quotient bit per cycle
// DONE  | result held until EX advances
module ex_muldiv_unit #(
    parameter int XLEN         = 64,
    parameter bit HAS_WORD_OPS = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam int SH = XLEN - 32;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic            w_q;
    logic            a_neg_q;
    logic            b_neg_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opb;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] result_q;
    logic            done_q;
    logic            busy_q;

    logic            word;
    logic [2:0]      op_eff;
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] a_op;
    logic [XLEN-1:0] b_op;
    logic [XLEN-1:0] min_val;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] spec_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   hi_nx;
    logic [XLEN-1:0]   lo_nx;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   res_nx;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    // word results are the low 32 bits sign-extended
    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] x, input logic w);
        return w ? sext32(x[31:0]) : x;
    endfunction

    // decode the incoming instruction at its operative width
    always_comb begin
        word   = bus.op_w & HAS_WORD_OPS;
        // word ops have no high-half multiplies; they all collapse to MULW
        op_eff = (word && !bus.op[2]) ? 3'b000 : bus.op;
        a_sgn  = !(op_eff == 3'b011 || op_eff == 3'b101 || op_eff == 3'b111);
        b_sgn  = (op_eff == 3'b000 || op_eff == 3'b001 || op_eff == 3'b100 || op_eff == 3'b110);
        if (word) begin
            a_op    = a_sgn ? sext32(bus.src_a[31:0]) : XLEN'(bus.src_a[31:0]);
            b_op    = b_sgn ? sext32(bus.src_b[31:0]) : XLEN'(bus.src_b[31:0]);
            min_val = sext32(32'h8000_0000);
        end else begin
            a_op    = bus.src_a;
            b_op    = bus.src_b;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg    = a_sgn & a_op[XLEN-1];
        b_neg    = b_sgn & b_op[XLEN-1];
        a_mag    = a_neg ? -a_op : a_op;
        b_mag    = b_neg ? -b_op : b_op;
        div_zero = (b_op == '0);
        div_ovf  = (op_eff == 3'b100 || op_eff == 3'b110) && (a_op == min_val) && (b_op == '1);
        special  = op_eff[2] && (div_zero || div_ovf);
        if (div_zero)
            spec_res = op_eff[1] ? fin(a_op, word) : '1;
        else
            spec_res = op_eff[1] ? '0 : fin(a_op, word);
    end

    // one iteration step plus the sign-corrected result of that step
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        div_sh   = {hi, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, opb};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_nx = div_diff[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = div_sh[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod     = {hi_nx, lo_nx};
        prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quo_fix  = (a_neg_q ^ b_neg_q) ? -lo_nx : lo_nx;
        rem_fix  = a_neg_q ? -hi_nx : hi_nx;
        // a 32-iteration product sits XLEN-32 bits up in the accumulator
        case (op_q)
            3'b000:         raw = w_q ? prod_fix[SH +: XLEN] : prod_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         raw = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101: raw = quo_fix;
            default:        raw = rem_fix;
        endcase
        res_nx = fin(raw, w_q);
    end

    // control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            cnt      <= '0;
            op_q     <= '0;
            w_q      <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opb      <= '0;
        end else if (bus.flush) begin
            state  <= IDLE;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= op_eff;
                        w_q     <= word;
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                        if (special) begin
                            result_q <= spec_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            hi     <= '0;
                            // word dividends start at the top so 32 shifts consume them
                            lo     <= (op_eff[2] && word) ? (a_mag << SH) : a_mag;
                            opb    <= b_mag;
                            cnt    <= word ? CW'(32) : CW'(XLEN);
                            busy_q <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result_q <= res_nx;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.advance) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.stallreq = ((state == IDLE) && bus.start && !bus.flush) || (state == CALC);
endmodule
